// File: rtl/button_event_scheduler_if.sv
// Button event scheduler bus.
// Carries the debounced button levels in, and the event stream and the
// sample_tick strobe out.
//   btn_db      debounced button levels (bit 0 = highest priority)
//   evt_ready   consumer accepts the event on a clk edge with evt_valid
//   evt_valid   event available
//   evt_id      button index 0..4
//   evt_repeat  1 = auto-repeat event, 0 = press event
//   sample_tick one-cycle pacing strobe
// modport slave is the scheduler side; modport master is the environment side.
interface button_event_scheduler_if;
   logic [4:0] btn_db;
   logic       evt_ready;
   logic       evt_valid;
   logic [2:0] evt_id;
   logic       evt_repeat;
   logic       sample_tick;

   modport master (output btn_db, evt_ready,
                   input  evt_valid, evt_id, evt_repeat, sample_tick);
   modport slave  (input  btn_db, evt_ready,
                   output evt_valid, evt_id, evt_repeat, sample_tick);
endinterface

// File: rtl/button_event_scheduler.sv
// Button event scheduler.
// Turns rising edges on five debounced buttons into press events, and a
// continuously held button into auto-repeat events. Events come out one at a
// time through a valid/ready slot. Press events have priority over repeats,
// and lower button indices have priority over higher ones.
// Ports:
//   clk  system clock (rising edge)
//   rst  asynchronous, active-high reset
//   bus  button_event_scheduler_if.slave (btn_db, evt_ready in;
//        evt_valid, evt_id, evt_repeat, sample_tick out)
module button_event_scheduler #(
   parameter int TICK_DIV     = 100000,
   parameter int HOLD_TICKS   = 500,
   parameter int REPEAT_TICKS = 100
) (
   input  logic                       clk,
   input  logic                       rst,
   button_event_scheduler_if.slave    bus
);

   localparam int TW   = $clog2(TICK_DIV);
   localparam int HMAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
   localparam int HW   = $clog2(HMAX + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_HOLD   = 2'd1;
   localparam logic [1:0] S_REPEAT = 2'd2;

   // Tick divider
   logic [TW-1:0] tcnt;
   logic          tick;

   assign tick = (tcnt == TW'(TICK_DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       tcnt <= '0;
      else if (tick) tcnt <= '0;
      else           tcnt <= tcnt + TW'(1);
   end

   // Edge detect and pending presses
   logic [4:0] prev_btn, pending, press, gnt_mask;
   logic       evt_valid, evt_repeat;
   logic [2:0] evt_id;
   logic       load_ok, gnt_any, press_load, rep_load;
   logic [2:0] gnt_id;

   logic [1:0]    state, state_nxt;
   logic [2:0]    track;
   logic [HW-1:0] hcnt, hcnt_nxt;
   logic          rep_pend, rep_pend_nxt, due, released;

   assign press   = bus.btn_db & ~prev_btn;
   assign load_ok = !evt_valid || bus.evt_ready;

   // Lowest set pending bit wins; the loop runs downward so the last hit is the lowest.
   always_comb begin
      gnt_any = 1'b0;
      gnt_id  = 3'd0;
      for (int i = 4; i >= 0; i--) begin
         if (pending[i]) begin
            gnt_any = 1'b1;
            gnt_id  = 3'(i);
         end
      end
   end

   assign press_load = load_ok && gnt_any;
   assign rep_load   = load_ok && !gnt_any && rep_pend;
   assign gnt_mask   = press_load ? (5'b00001 << gnt_id) : 5'b00000;

   // A press arriving in the same cycle as its grant survives (set wins).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_btn <= 5'b11111;
         pending  <= 5'b00000;
      end else begin
         prev_btn <= bus.btn_db;
         pending  <= (pending & ~gnt_mask) | press;
      end
   end

   // Output slot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         evt_valid  <= 1'b0;
         evt_id     <= 3'd0;
         evt_repeat <= 1'b0;
      end else if (load_ok) begin
         if (gnt_any) begin
            evt_valid  <= 1'b1;
            evt_id     <= gnt_id;
            evt_repeat <= 1'b0;
         end else if (rep_pend) begin
            evt_valid  <= 1'b1;
            evt_id     <= track;
            evt_repeat <= 1'b1;
         end else begin
            evt_valid  <= 1'b0;
         end
      end
   end

   assign bus.evt_valid   = evt_valid;
   assign bus.evt_id      = evt_id;
   assign bus.evt_repeat  = evt_repeat;
   assign bus.sample_tick = tick;

   // Repeat FSM. Priority: retarget, then release, then tick.
   assign released = (state != S_IDLE) && !bus.btn_db[track];

   always_comb begin
      state_nxt = state;
      hcnt_nxt  = hcnt;
      due       = 1'b0;
      if (press_load) begin
         state_nxt = S_HOLD;
         hcnt_nxt  = '0;
      end else if (released) begin
         state_nxt = S_IDLE;
         hcnt_nxt  = '0;
      end else if (tick && state == S_HOLD) begin
         if (hcnt == HW'(HOLD_TICKS - 1)) begin
            due       = 1'b1;
            hcnt_nxt  = '0;
            state_nxt = S_REPEAT;
         end else begin
            hcnt_nxt  = hcnt + HW'(1);
         end
      end else if (tick && state == S_REPEAT) begin
         if (hcnt == HW'(REPEAT_TICKS - 1)) begin
            due      = 1'b1;
            hcnt_nxt = '0;
         end else begin
            hcnt_nxt = hcnt + HW'(1);
         end
      end
   end

   // A due repeat just ORs in, so an undelivered one is never doubled.
   assign rep_pend_nxt = (press_load || released) ? 1'b0
                                                  : ((rep_pend && !rep_load) || due);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         hcnt     <= '0;
         track    <= 3'd0;
         rep_pend <= 1'b0;
      end else begin
         state    <= state_nxt;
         hcnt     <= hcnt_nxt;
         rep_pend <= rep_pend_nxt;
         if (press_load) track <= gnt_id;
      end
   end

endmodule

// File: tb/tb_button_event_scheduler.sv
module tb_button_event_scheduler;
   localparam int TD = 4;
   localparam int H  = 3;
   localparam int R  = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   button_event_scheduler_if bus();

   button_event_scheduler #(.TICK_DIV(TD), .HOLD_TICKS(H), .REPEAT_TICKS(R)) dut (
      .clk(clk), .rst(rst), .bus(bus));

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: event slot, pending set, and a held-button tracker that
   // counts ticks since the last press event and fires at H, H+R, H+2R, ...
   int         m_tc;
   logic [4:0] m_prev, m_pend;
   bit         m_rp, m_act, m_v, m_rep;
   int         m_trk, m_t, m_id;

   task automatic m_reset();
      m_tc = 0; m_prev = 5'b11111; m_pend = 0; m_rp = 0; m_act = 0;
      m_trk = 0; m_t = 0; m_v = 0; m_id = 0; m_rep = 0;
   endtask

   task automatic m_step(input logic [4:0] b, input bit r);
      bit tk;
      bit retgt;
      int g;
      logic [4:0] pr;
      tk = (m_tc == TD - 1);
      pr = b & ~m_prev;
      retgt = 0;
      g = -1;
      if (!m_v || r) begin
         for (int i = 0; i < 5; i++) if (m_pend[i] && g < 0) g = i;
         if (g >= 0) begin
            m_v = 1; m_id = g; m_rep = 0; m_pend[g] = 1'b0; retgt = 1;
         end else if (m_rp) begin
            m_v = 1; m_id = m_trk; m_rep = 1; m_rp = 0;
         end else begin
            m_v = 0;
         end
      end
      if (retgt) begin
         m_act = 1; m_trk = g; m_t = 0; m_rp = 0;
      end else if (m_act && !b[m_trk]) begin
         m_act = 0; m_rp = 0;
      end else if (m_act && tk) begin
         m_t++;
         if (m_t == H || (m_t > H && (m_t - H) % R == 0)) m_rp = 1;
      end
      m_pend = m_pend | pr;
      m_prev = b;
      m_tc   = (m_tc + 1) % TD;
   endtask

   task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic check_model();
      logic [7:0] got, exp;
      got = {2'b00, bus.sample_tick, bus.evt_valid,
             bus.evt_valid ? bus.evt_id : 3'd0, bus.evt_valid ? bus.evt_repeat : 1'b0};
      exp = {2'b00, 1'(m_tc == TD - 1), 1'(m_v),
             m_v ? 3'(m_id) : 3'd0, m_v ? 1'(m_rep) : 1'b0};
      chk("model", got, exp);
   endtask

   // Drive at the current (negedge) point, clock once, sample at next negedge.
   task automatic step(input logic [4:0] b, input bit r);
      bus.btn_db = b;
      bus.evt_ready = r;
      @(posedge clk);
      if (rst) m_reset(); else m_step(b, r);
      @(negedge clk);
      check_model();
   endtask

   task automatic chk_evt(input string nm, input bit v, input logic [2:0] id, input bit rep);
      if (v) chk(nm, {3'b000, bus.evt_valid, bus.evt_id, bus.evt_repeat}, {3'b000, 1'b1, id, rep});
      else   chk(nm, {7'b0, bus.evt_valid}, 8'h00);
   endtask

   typedef struct {
      logic [4:0] btn;
      bit         rdy;
      bit         v;
      logic [2:0] id;
      bit         rep;
   } vec_t;

   vec_t tbl[14];

   initial begin
      logic [4:0] b;
      bit r;
      int pcnt, rcnt, last, gap;

      // press/priority then backpressure; expected event after each edge
      tbl[0]  = '{5'b00000, 1'b1, 1'b0, 3'd0, 1'b0};
      tbl[1]  = '{5'b01001, 1'b1, 1'b0, 3'd0, 1'b0};
      tbl[2]  = '{5'b01001, 1'b1, 1'b1, 3'd0, 1'b0};
      tbl[3]  = '{5'b01001, 1'b1, 1'b1, 3'd3, 1'b0};
      tbl[4]  = '{5'b01001, 1'b1, 1'b0, 3'd0, 1'b0};
      tbl[5]  = '{5'b00000, 1'b1, 1'b0, 3'd0, 1'b0};
      tbl[6]  = '{5'b00100, 1'b0, 1'b0, 3'd0, 1'b0};
      tbl[7]  = '{5'b00110, 1'b0, 1'b1, 3'd2, 1'b0};
      tbl[8]  = '{5'b00110, 1'b0, 1'b1, 3'd2, 1'b0};
      tbl[9]  = '{5'b00100, 1'b0, 1'b1, 3'd2, 1'b0};
      tbl[10] = '{5'b00110, 1'b0, 1'b1, 3'd2, 1'b0};
      tbl[11] = '{5'b00110, 1'b1, 1'b1, 3'd1, 1'b0};
      tbl[12] = '{5'b00110, 1'b1, 1'b0, 3'd0, 1'b0};
      tbl[13] = '{5'b00000, 1'b1, 1'b0, 3'd0, 1'b0};

      rst = 1'b1;
      bus.btn_db = 5'b00000;
      bus.evt_ready = 1'b0;
      m_reset();
      @(negedge clk);
      @(negedge clk);
      chk("reset_outputs", {4'b0, bus.sample_tick, bus.evt_valid, bus.evt_id[0], bus.evt_repeat}, 8'h00);
      chk("reset_id", {5'b0, bus.evt_id}, 8'h00);
      rst = 1'b0;

      // sample_tick cadence after reset release
      for (int k = 1; k <= 13; k++) begin
         step(5'b00000, 1'b1);
         chk("tick", {7'b0, bus.sample_tick}, {7'b0, 1'((k % TD) == TD - 1)});
      end

      for (int i = 0; i < 14; i++) begin
         step(tbl[i].btn, tbl[i].rdy);
         chk_evt($sformatf("vec%0d", i), tbl[i].v, tbl[i].id, tbl[i].rep);
      end

      // auto-repeat on a held button 4
      pcnt = 0; rcnt = 0; last = 0;
      for (int c = 0; c < 40; c++) begin
         step(5'b10000, 1'b1);
         if (bus.evt_valid) begin
            chk("hold_id", {5'b0, bus.evt_id}, 8'd4);
            if (!bus.evt_repeat) begin
               pcnt++;
               last = c;
            end else begin
               rcnt++;
               gap = c - last;
               if (rcnt == 1) chk("first_rep_gap", 8'(gap >= 2*TD+2 && gap <= 3*TD+1), 8'd1);
               else           chk("rep_gap", 8'(gap), 8'(2*TD));
               last = c;
            end
         end
      end
      chk("press_count", 8'(pcnt), 8'd1);
      chk("rep_count_min", 8'(rcnt >= 3), 8'd1);
      step(5'b00000, 1'b1);
      rcnt = 0;
      for (int c = 0; c < 20; c++) begin
         step(5'b00000, 1'b1);
         if (bus.evt_valid) rcnt++;
      end
      chk("after_release", 8'(rcnt), 8'd0);

      // reset with a button held and an event waiting
      step(5'b00001, 1'b0);
      step(5'b00001, 1'b0);
      chk_evt("held_before_rst", 1'b1, 3'd0, 1'b0);
      rst = 1'b1;
      m_reset();
      #1;
      chk("rst_clears_valid", {6'b0, bus.evt_valid, bus.sample_tick}, 8'h00);
      for (int c = 0; c < 3; c++) step(5'b00001, 1'b0);
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step(5'b00001, 1'b1);
         chk_evt("held_thru_rst", 1'b0, 3'd0, 1'b0);
      end
      step(5'b00000, 1'b1);
      step(5'b00000, 1'b1);
      step(5'b00001, 1'b1);
      chk_evt("repress_lat1", 1'b0, 3'd0, 1'b0);
      step(5'b00001, 1'b1);
      chk_evt("repress_evt", 1'b1, 3'd0, 1'b0);
      step(5'b00001, 1'b1);
      chk_evt("repress_once", 1'b0, 3'd0, 1'b0);

      // random buttons and backpressure against the model
      b = 5'b00000;
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < 5; i++) if ($urandom_range(0, 11) == 0) b[i] = ~b[i];
         r = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 499) == 0) begin
            rst = 1'b1;
            step(b, r);
            rst = 1'b0;
         end else begin
            step(b, r);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
